rr_arbiter8: RTL

- 8-requester round-robin arbiter with grant locking and an optional hold limit.
- Shares one downstream resource (bus, ALU port, memory port) among 8 clients.
- Any-request detection is an 8-input OR reduction of the request vector.
- Grant is registered, one-hot, and held until the owner releases it or is pre-empted.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick8.sv | 26 ++
 rtl/rr_arbiter8.sv | 104 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int NREQ = 8;
  localparam int ID_W = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic logic [NREQ-1:0] onehot8(input logic [ID_W-1:0] id);
    return NREQ'(1) << id;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set req bit at or above ptr,
// wrapping from 7 to 0.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] id
);

  logic [ID_W-1:0] idx;

  // NOTE: every variable written in always_comb gets a default first, or a latch is inferred.
  always_comb begin
    found = |req;
    id    = ptr;
    idx   = ptr;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + ID_W'(i);
      if (req[idx]) id = idx;
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with grant locking, one-cycle bus turnaround
// between owners, and optional hold-limit pre-emption.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            any_req,
  output logic            preempt
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? CNT_W'(0) : CNT_W'(MAX_HOLD - 1);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic            preempt_q, preempt_d;

  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic            others_waiting;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .id    (pick_id)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      preempt_q  <= preempt_d;
    end
  end

  assign others_waiting = |(req & ~onehot8(grant_id_q));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    preempt_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && pick_found) begin
          state_d    = GRANT;
          grant_d    = onehot8(pick_id);
          grant_id_d = pick_id;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!req[grant_id_q]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = grant_id_q + ID_W'(1);
        end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_LAST && others_waiting) begin
          state_d   = IDLE;
          grant_d   = '0;
          preempt_d = 1'b1;
          ptr_d     = grant_id_q + ID_W'(1);
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant       = grant_q;
    grant_valid = |grant_q;
    grant_id    = grant_id_q;
    preempt     = preempt_q;
    any_req     = |req;
  end

endmodule
